// File: rtl/twiddler_pipe.sv
// twiddler_pipe: 3-stage pipelined complex twiddle multiply, Y = A*W or A*conj(W), with valid/ready,
// tag sideband, round/saturate and a sticky saturation counter. Define TWIDDLER_ROUND_EN for round-half-up.
module twiddler_pipe #(
  parameter int DW   = 11,
  parameter int TW   = 17,
  parameter int FRAC = 16,
  parameter int TAGW = 8,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] a,
  input  logic [TW-1:0]   wr,
  input  logic [TW-1:0]   wi,
  input  logic            conj,
  input  logic [TAGW-1:0] tag_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] y,
  output logic [TAGW-1:0] tag_out,
  output logic [CNTW-1:0] sat_cnt,
  input  logic            sat_clr
);
  localparam int PW = DW + TW;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] YMAX = SW'((longint'(1) << (DW - 1)) - 1);
  localparam logic signed [SW-1:0] YMIN = SW'(-(longint'(1) << (DW - 1)));
`ifdef TWIDDLER_ROUND_EN
  localparam logic signed [SW-1:0] RND = SW'(longint'(1) << (FRAC - 1));
`endif

  logic                   stall, adv;
  logic                   v1, v2, v3;
  logic signed [DW-1:0]   ar1, ai1;
  logic signed [TW-1:0]   wr1, wi1;
  logic                   c1, c2;
  logic [TAGW-1:0]        t1, t2;
  logic signed [PW-1:0]   p_rr, p_ii, p_ri, p_ir;
  logic signed [SW-1:0]   pr_sum, pi_sum, pr_sh, pi_sh;
  logic signed [DW-1:0]   yr_n, yi_n;
  logic                   sat_r, sat_i;
  logic [CNTW:0]          cnt_sum;

  // A stall freezes every stage at once, so bubbles are held in place rather than squeezed out.
  assign stall     = v3 & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = adv;
  assign out_valid = v3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar1 <= '0;
      ai1 <= '0;
      wr1 <= '0;
      wi1 <= '0;
      c1  <= 1'b0;
      t1  <= '0;
    end else if (adv && in_valid) begin
      ar1 <= $signed(a[2*DW-1:DW]);
      ai1 <= $signed(a[DW-1:0]);
      wr1 <= $signed(wr);
      wi1 <= $signed(wi);
      c1  <= conj;
      t1  <= tag_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
      c2   <= 1'b0;
      t2   <= '0;
    end else if (adv && v1) begin
      p_rr <= PW'(ar1) * PW'(wr1);
      p_ii <= PW'(ai1) * PW'(wi1);
      p_ri <= PW'(ar1) * PW'(wi1);
      p_ir <= PW'(ai1) * PW'(wr1);
      c2   <= c1;
      t2   <= t1;
    end
  end

  always_comb begin
    if (c2) begin
      pr_sum = {p_rr[PW-1], p_rr} + {p_ii[PW-1], p_ii};
      pi_sum = {p_ir[PW-1], p_ir} - {p_ri[PW-1], p_ri};
    end else begin
      pr_sum = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
      pi_sum = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};
    end
`ifdef TWIDDLER_ROUND_EN
    pr_sh = (pr_sum + RND) >>> FRAC;
    pi_sh = (pi_sum + RND) >>> FRAC;
`else
    pr_sh = pr_sum >>> FRAC;
    pi_sh = pi_sum >>> FRAC;
`endif
    sat_r = 1'b0;
    sat_i = 1'b0;
    if (pr_sh > YMAX) begin
      yr_n  = YMAX[DW-1:0];
      sat_r = 1'b1;
    end else if (pr_sh < YMIN) begin
      yr_n  = YMIN[DW-1:0];
      sat_r = 1'b1;
    end else begin
      yr_n = pr_sh[DW-1:0];
    end
    if (pi_sh > YMAX) begin
      yi_n  = YMAX[DW-1:0];
      sat_i = 1'b1;
    end else if (pi_sh < YMIN) begin
      yi_n  = YMIN[DW-1:0];
      sat_i = 1'b1;
    end else begin
      yi_n = pi_sh[DW-1:0];
    end
    cnt_sum = {1'b0, sat_cnt} + (CNTW+1)'(sat_r) + (CNTW+1)'(sat_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y       <= '0;
      tag_out <= '0;
    end else if (adv && v2) begin
      y       <= {yr_n, yi_n};
      tag_out <= t2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (adv && v2) begin
      sat_cnt <= cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];
    end
  end

endmodule
